cdc_event_arbiter: RTL
======================

Name: cdc_event_arbiter

Overview:
- Source-side controller for a single-bit clock-domain crossing.
- Collects single-cycle event pulses from N_REQ local requesters and arbitrates among them round-robin.
- Sequences one 4-phase req/ack handshake per event across the crossing, holding a requester ID stable while req is high.
- The ack returns from the far domain and is synchronized internally. Completion and drop/timeout status go back to the requesters.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of id_out.
- SYNC_STAGES, 2, flop stages on ack_in (>=2).
- TIMEOUT, 1024, cycles allowed per handshake phase before timeout_err is set.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ev_in  in  N_REQ  one-cycle event pulse per requester.
- ev_pending  out  N_REQ  event latched, not yet granted.
- ev_drop  out  N_REQ  one-cycle pulse: event lost because already pending.
- done  out  N_REQ  one-cycle pulse: handshake for that requester complete.
- req_out  out  1  level request to the far domain; registered, glitch-free.
- id_out  out  ID_W  granted requester ID; stable whenever req_out=1.
- ack_in  in  1  asynchronous ack from the far domain.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky; a handshake phase exceeded TIMEOUT.

Behaviour:
- Reset (async, immediate):
  - All outputs 0; pending=0; state=IDLE; sync chain=0; timeout counter=0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Reset mid-handshake drops req_out at once; the far side must tolerate this.
- Pending bits:
  - ev_in[i]=1 and pending[i]=0 sets pending[i] next cycle.
  - ev_in[i]=1 and pending[i]=1 pulses ev_drop[i] next cycle; pending unchanged.
  - Grant clears pending[i]. Grant clear and ev_in[i] in the same cycle: set wins, pending[i] stays 1, no drop.
- ack sync: ack_s is ack_in after SYNC_STAGES flops. Only ack_s is used by logic.
- FSM states IDLE, SETUP, ASSERT, RELEASE:
  - IDLE, any pending=1: grant the first pending index searching from ptr+1 modulo N_REQ; ptr<=grant; id_out<=grant; clear pending[grant]; go to SETUP.
  - SETUP (exactly 1 cycle): id_out settles; next cycle req_out<=1 and go to ASSERT. This guarantees one cycle of id setup before req rises.
  - ASSERT: hold req_out=1 until ack_s=1, then req_out<=0 and go to RELEASE.
  - RELEASE: wait ack_s=0, then go to IDLE and pulse done[id_out] for one cycle.
  - id_out is held until the next grant.
- Latency, zero contention, ev_in[i] at cycle n:
  - pending[i]=1 at n+1.
  - SETUP and id_out=i at n+2.
  - req_out=1 at n+3.
  - After ack_in rises at m: req_out=0 at m+SYNC_STAGES+1.
  - After ack_in falls at k: done[i] at k+SYNC_STAGES+1.
- Timeout:
  - Counter clears on entry to ASSERT and to RELEASE, increments each cycle in those states, saturates at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err (sticky until rst).
  - The FSM keeps waiting; the handshake is never abandoned.
- Other outputs:
  - busy=1 in SETUP, ASSERT and RELEASE.
  - ev_pending mirrors the pending register.

Decomposition:
- Package cdc_arb_pkg:
  - state encoding localparams (IDLE=2'd0, SETUP=2'd1, ASSERT=2'd2, RELEASE=2'd3);
  - the clog2 helper function.
- One sub-module, ack_sync: SYNC_STAGES-deep flop chain with async reset.
- Round-robin select stays inline as a function.

Test Plan:
- Single event: ev_in=4'b0100 one cycle, far-side model acks 5 cycles after req rises and drops ack 5 cycles after req falls -> id_out=2 at n+2, req_out=1 at n+3, done=4'b0100 exactly once, busy returns 0.
- Contention: ev_in=4'b1111 in one cycle -> grants in order 0,1,2,3, one done pulse each; then ev_in=4'b1001 -> grant 0 then 3.
- Drop / re-arm:
  - ev_in[1] twice while pending[1]=1 -> one ev_drop[1] pulse, one handshake only.
  - ev_in[1] in the same cycle as its grant -> pending[1] re-set, second handshake follows.
- Timeout: TIMEOUT=16, far model never acks -> timeout_err=1 at 16 cycles after ASSERT entry, req_out stays 1. Late ack then completes normally; timeout_err stays 1.
- Async reset during ASSERT: rst pulse of 3 ns mid-cycle -> req_out, busy, pending and done go 0 immediately. After release, ev_in[3] is handled from ptr reset (requester 0 first priority).
- Id stability: random ev_in and ack delays (1-20 cycles) for 10k events -> assertion that id_out never changes while req_out=1, and done count + drop count == event count.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC event arbiter.
package cdc_arb_pkg;

  // Handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Bits needed to hold values 0..v-1; never less than 1 so a vector is always legal.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for the ack returning from the far clock domain.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ack_in,
  output logic ack_s
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous ack through the flop chain; the last stage is the only safe tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], ack_in};
  end

  assign ack_s = chain[STAGES-1];

endmodule

// File: rtl/cdc_event_arbiter.sv
// Source-side controller for a single-bit req/ack crossing: latches requester
// events, picks one round-robin and runs one 4-phase handshake per event.
//
// state   | meaning
// IDLE    | no handshake; grant the next pending requester if any
// SETUP   | id_out driven, one cycle of setup before req_out rises
// ASSERT  | req_out high, waiting for synchronized ack high
// RELEASE | req_out low, waiting for synchronized ack low, then done pulse
module cdc_event_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = clog2(N_REQ),
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] ev_in,
  output logic [N_REQ-1:0] ev_pending,
  output logic [N_REQ-1:0] ev_drop,
  output logic [N_REQ-1:0] done,
  output logic             req_out,
  output logic [ID_W-1:0]  id_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err
);

  localparam int TMR_W = clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic             ack_s;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] grant_clr;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic [TMR_W-1:0] tmr;

  ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .ack_in (ack_in),
    .ack_s  (ack_s)
  );

  // First set bit of req searching upward from last+1, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [ID_W-1:0]  last);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] cand;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last) + k) % N_REQ);
      if (req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // Round-robin choice and the pending bit it consumes when IDLE grants.
  always_comb begin
    {grant_vld, grant_id} = rr_pick(pending, ptr);
    grant_clr = '0;
    if (state == IDLE && grant_vld)
      grant_clr = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  end

  // Pending latch: a new event wins over a same-cycle grant clear, so it is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ev_drop <= '0;
    end else begin
      pending <= ev_in | (pending & ~grant_clr);
      ev_drop <= ev_in & pending & ~grant_clr;
    end
  end

  assign ev_pending = pending;

  // Handshake sequencer; the phase timer is a down-counter whose terminal count flags a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= ID_W'(N_REQ - 1);
      id_out      <= '0;
      req_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= '0;
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ptr    <= grant_id;
            id_out <= grant_id;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          req_out <= 1'b1;
          tmr     <= TMR_W'(TIMEOUT);
          state   <= ASSERT;
        end
        ASSERT: begin
          if (ack_s) begin
            req_out <= 1'b0;
            tmr     <= TMR_W'(TIMEOUT);
            state   <= RELEASE;
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
            if (tmr == TMR_W'(1)) timeout_err <= 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            busy  <= 1'b0;
            done  <= {{(N_REQ-1){1'b0}}, 1'b1} << id_out;
            state <= IDLE;
          end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
            if (tmr == TMR_W'(1)) timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
